// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage types and constants.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        DRAIN    = 2'd2,
        EXC      = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;
    localparam logic [31:0] EXCEPTION_ADDR   = 32'h0000_0100;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

endpackage

// File: rtl/cpu_fetch_if.sv
// I-cache request/response bus between fetch (master) and cache (slave).
interface cpu_fetch_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   ic_req;
    logic [ADDR_WIDTH-1:0]  ic_addr;
    logic                   ic_hit;
    logic [INSTR_WIDTH-1:0] ic_data;

    modport master (
        output ic_req,
        output ic_addr,
        input  ic_hit,
        input  ic_data
    );

    modport slave (
        input  ic_req,
        input  ic_addr,
        output ic_hit,
        output ic_data
    );
endinterface

// File: rtl/cpu_fetch_hold_buf.sv
// One-entry holding register for an I-cache fill that lands while fetch is stalled.
module cpu_fetch_hold_buf #(
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   consume,
    input  logic [INSTR_WIDTH-1:0] load_data,
    output logic                   valid,
    output logic [INSTR_WIDTH-1:0] data
);

    logic                   valid_q;
    logic                   valid_d;
    logic [INSTR_WIDTH-1:0] data_q;
    logic [INSTR_WIDTH-1:0] data_d;

    // Load wins over consume; consume just drops the valid bit.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (consume) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register state, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/cpu_fetch.sv
// Fetch stage: PC register, iTLB lookup, I-cache request and decode-facing registers.
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   jump,
    input  logic [ADDR_WIDTH-1:0]  jump_pc,
    input  logic                   supervisor,
    output logic [ADDR_WIDTH-1:0]  itlb_vaddr,
    input  logic [ADDR_WIDTH-1:0]  itlb_paddr,
    input  logic                   itlb_miss,
    cpu_fetch_if.master            ic,
    output logic [INSTR_WIDTH-1:0] dec_instr,
    output logic [ADDR_WIDTH-1:0]  dec_next_pc,
    output logic                   dec_nop,
    output logic                   dec_exc_raise,
    output logic [ADDR_WIDTH-1:0]  dec_exc_pc,
    output logic [ADDR_WIDTH-1:0]  dec_exc_vaddr
);

    fetch_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
    logic [INSTR_WIDTH-1:0] dec_instr_q, dec_instr_d;
    logic [ADDR_WIDTH-1:0]  dec_next_pc_q, dec_next_pc_d;
    logic                   dec_nop_q, dec_nop_d;
    logic                   dec_exc_raise_q, dec_exc_raise_d;
    logic [ADDR_WIDTH-1:0]  dec_exc_pc_q, dec_exc_pc_d;
    logic [ADDR_WIDTH-1:0]  dec_exc_vaddr_q, dec_exc_vaddr_d;

    logic                   miss_eff_s;
    logic [ADDR_WIDTH-1:0]  pc_plus4_s;
    logic [ADDR_WIDTH-1:0]  translated_addr_s;
    logic                   ic_req_s;
    logic [ADDR_WIDTH-1:0]  ic_addr_s;
    logic                   hit_s;
    logic [INSTR_WIDTH-1:0] fill_data_s;
    logic                   hold_load_s;
    logic                   hold_valid_s;
    logic [INSTR_WIDTH-1:0] hold_data_s;

    assign miss_eff_s        = itlb_miss & ~supervisor;
    assign pc_plus4_s        = pc_q + ADDR_WIDTH'(32'd4);
    assign translated_addr_s = supervisor ? pc_q : itlb_paddr;

    // Request valid/address; an outstanding miss keeps its captured address even after a redirect.
    always_comb begin
        ic_req_s  = 1'b0;
        ic_addr_s = translated_addr_s;
        if (reset) begin
            ic_req_s = 1'b0;
        end else begin
            case (state_q)
                RUN:      ic_req_s = ~stall & ~miss_eff_s;
                WAIT_MEM: begin
                    ic_req_s  = ~hold_valid_s;
                    ic_addr_s = req_addr_q;
                end
                DRAIN:    begin
                    ic_req_s  = ~hold_valid_s;
                    ic_addr_s = req_addr_q;
                end
                EXC:      ic_req_s = 1'b0;
                default:  ic_req_s = 1'b0;
            endcase
        end
    end

    // A hit only counts against our own request; a buffered fill counts as a hit once unstalled.
    assign hit_s       = (ic.ic_hit & ic_req_s) | hold_valid_s;
    assign fill_data_s = hold_valid_s ? hold_data_s : ic.ic_data;
    assign hold_load_s = stall & ic.ic_hit & ic_req_s;

    cpu_fetch_hold_buf #(
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_hold_buf (
        .clock     (clock),
        .reset     (reset),
        .load      (hold_load_s),
        .consume   (~stall),
        .load_data (ic.ic_data),
        .valid     (hold_valid_s),
        .data      (hold_data_s)
    );

    // Next-state, PC and decode-register logic; priority reset > stall > jump > exception > hit/miss.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        req_addr_d      = req_addr_q;
        dec_instr_d     = dec_instr_q;
        dec_next_pc_d   = dec_next_pc_q;
        dec_nop_d       = dec_nop_q;
        dec_exc_raise_d = dec_exc_raise_q;
        dec_exc_pc_d    = dec_exc_pc_q;
        dec_exc_vaddr_d = dec_exc_vaddr_q;
        if (reset) begin
            state_d         = RUN;
            pc_d            = RESET_PC;
            req_addr_d      = '0;
            dec_instr_d     = '0;
            dec_next_pc_d   = '0;
            dec_nop_d       = 1'b1;
            dec_exc_raise_d = 1'b0;
            dec_exc_pc_d    = '0;
            dec_exc_vaddr_d = '0;
        end else if (stall) begin
            state_d = state_q;
        end else begin
            dec_exc_raise_d = 1'b0;
            case (state_q)
                RUN: begin
                    req_addr_d = translated_addr_s;
                    if (jump) begin
                        pc_d      = jump_pc;
                        dec_nop_d = 1'b1;
                    end else if (miss_eff_s) begin
                        dec_exc_raise_d = 1'b1;
                        dec_exc_pc_d    = pc_q;
                        dec_exc_vaddr_d = pc_q;
                        dec_nop_d       = 1'b1;
                        state_d         = EXC;
                    end else if (hit_s) begin
                        dec_instr_d   = fill_data_s;
                        dec_next_pc_d = pc_plus4_s;
                        dec_nop_d     = 1'b0;
                        pc_d          = pc_plus4_s;
                    end else begin
                        dec_nop_d = 1'b1;
                        state_d   = WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (jump) begin
                        pc_d      = jump_pc;
                        dec_nop_d = 1'b1;
                        state_d   = hit_s ? RUN : DRAIN;
                    end else if (hit_s) begin
                        dec_instr_d   = fill_data_s;
                        dec_next_pc_d = pc_plus4_s;
                        dec_nop_d     = 1'b0;
                        pc_d          = pc_plus4_s;
                        state_d       = RUN;
                    end else begin
                        dec_nop_d = 1'b1;
                    end
                end
                DRAIN: begin
                    dec_nop_d = 1'b1;
                    if (jump) begin
                        pc_d = jump_pc;
                    end else begin
                        pc_d = pc_q;
                    end
                    state_d = hit_s ? RUN : DRAIN;
                end
                EXC: begin
                    dec_nop_d = 1'b1;
                    if (jump) begin
                        pc_d    = jump_pc;
                        state_d = RUN;
                    end else begin
                        state_d = EXC;
                    end
                end
                default: begin
                    dec_nop_d = 1'b1;
                    state_d   = RUN;
                end
            endcase
        end
    end

    // State, PC and decode registers.
    always_ff @(posedge clock) begin
        state_q         <= state_d;
        pc_q            <= pc_d;
        req_addr_q      <= req_addr_d;
        dec_instr_q     <= dec_instr_d;
        dec_next_pc_q   <= dec_next_pc_d;
        dec_nop_q       <= dec_nop_d;
        dec_exc_raise_q <= dec_exc_raise_d;
        dec_exc_pc_q    <= dec_exc_pc_d;
        dec_exc_vaddr_q <= dec_exc_vaddr_d;
    end

    assign itlb_vaddr    = pc_q;
    assign ic.ic_req     = ic_req_s;
    assign ic.ic_addr    = ic_addr_s;
    assign dec_instr     = dec_instr_q;
    assign dec_next_pc   = dec_next_pc_q;
    assign dec_nop       = dec_nop_q;
    assign dec_exc_raise = dec_exc_raise_q;
    assign dec_exc_pc    = dec_exc_pc_q;
    assign dec_exc_vaddr = dec_exc_vaddr_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Scoreboard bench for cpu_fetch: directed stimulus pushes expected decode results, a monitor pops and compares.
module tb_cpu_fetch;
    import cpu_fetch_pkg::*;

    localparam int AW = 32;
    localparam int IW = 32;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] next_pc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump;
    logic [31:0] jump_pc;
    logic        supervisor;
    logic [31:0] itlb_vaddr;
    logic [31:0] itlb_paddr;
    logic        itlb_miss;
    logic [31:0] tlb_off;
    logic [31:0] dec_instr;
    logic [31:0] dec_next_pc;
    logic        dec_nop;
    logic        dec_exc_raise;
    logic [31:0] dec_exc_pc;
    logic [31:0] dec_exc_vaddr;
    logic        last_stall = 1'b0;

    exp_t        exp_q[$];
    logic [31:0] exc_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    cpu_fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) ic ();

    // Simple iTLB model: fixed offset translation.
    assign itlb_paddr = itlb_vaddr + tlb_off;

    cpu_fetch #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .RESET_PC    (32'h0000_1000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .jump          (jump),
        .jump_pc       (jump_pc),
        .supervisor    (supervisor),
        .itlb_vaddr    (itlb_vaddr),
        .itlb_paddr    (itlb_paddr),
        .itlb_miss     (itlb_miss),
        .ic            (ic.master),
        .dec_instr     (dec_instr),
        .dec_next_pc   (dec_next_pc),
        .dec_nop       (dec_nop),
        .dec_exc_raise (dec_exc_raise),
        .dec_exc_pc    (dec_exc_pc),
        .dec_exc_vaddr (dec_exc_vaddr)
    );

    always #5 clock = ~clock;

    // Remember whether the last edge was a stalled one (decode registers held).
    always @(posedge clock) last_stall <= stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push_instr(input logic [31:0] instr, input logic [31:0] next_pc);
        exp_t e;
        e.instr   = instr;
        e.next_pc = next_pc;
        exp_q.push_back(e);
    endtask

    // Monitor: every freshly registered non-bubble or exception is matched against the queues.
    initial begin
        exp_t        e;
        logic [31:0] epc;
        forever begin
            @(negedge clock);
            if (!last_stall && (dec_nop === 1'b0)) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got %h (dec_nop=0) expected no delivery", dec_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instr", dec_instr, e.instr);
                    chk("sb_next_pc", dec_next_pc, e.next_pc);
                end
            end
            if (!last_stall && (dec_exc_raise === 1'b1)) begin
                if (exc_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_exc: got exc_pc %h expected no exception", dec_exc_pc);
                end else begin
                    epc = exc_q.pop_front();
                    chk("sb_exc_pc", dec_exc_pc, epc);
                    chk("sb_exc_vaddr", dec_exc_vaddr, epc);
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        jump       = 1'b0;
        jump_pc    = 32'h0;
        supervisor = 1'b1;
        itlb_miss  = 1'b0;
        tlb_off    = 32'h0;
        ic.ic_hit  = 1'b1;
        ic.ic_data = 32'hBAD0_0BAD;
        #1;
        chk("reset_ic_req", ic.ic_req, 1'b0);
        cyc();
        cyc();
        chk("reset_pc", itlb_vaddr, 32'h0000_1000);
        chk("reset_nop", dec_nop, 1'b1);
        chk("reset_instr", dec_instr, 32'h0);
        chk("reset_next_pc", dec_next_pc, 32'h0);
        chk("reset_exc_raise", dec_exc_raise, 1'b0);
        chk("reset_exc_pc", dec_exc_pc, 32'h0);
        chk("reset_exc_vaddr", dec_exc_vaddr, 32'h0);
        chk("reset_ic_req_hold", ic.ic_req, 1'b0);

        // Back-to-back hits A0..A3.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ic.ic_hit  = 1'b1;
            ic.ic_data = 32'hA0 + 32'(i);
            push_instr(32'hA0 + 32'(i), 32'h1000 + 32'(4 * (i + 1)));
            #1;
            chk("stream_ic_addr", ic.ic_addr, 32'h1000 + 32'(4 * i));
            chk("stream_ic_req", ic.ic_req, 1'b1);
            cyc();
        end

        // Redirect in RUN squashes a same-cycle hit.
        ic.ic_hit  = 1'b1;
        ic.ic_data = 32'hBEEF;
        jump       = 1'b1;
        jump_pc    = 32'h1000;
        cyc();
        jump      = 1'b0;
        ic.ic_hit = 1'b0;
        #1;
        chk("squash_pc", itlb_vaddr, 32'h1000);
        chk("squash_nop", dec_nop, 1'b1);

        // Miss at 0x1000, fill after 3 cycles.
        chk("miss_addr_c0", ic.ic_addr, 32'h1000);
        cyc();
        for (int i = 0; i < 2; i++) begin
            chk("miss_addr_wait", ic.ic_addr, 32'h1000);
            chk("miss_nop_wait", dec_nop, 1'b1);
            chk("miss_req_wait", ic.ic_req, 1'b1);
            cyc();
        end
        ic.ic_hit  = 1'b1;
        ic.ic_data = 32'h55;
        push_instr(32'h55, 32'h1004);
        #1;
        chk("miss_addr_fill", ic.ic_addr, 32'h1000);
        chk("miss_nop_fill", dec_nop, 1'b1);
        cyc();
        ic.ic_hit = 1'b0;

        // Redirect during WAIT_MEM, stale fill discarded.
        #1;
        cyc();
        jump    = 1'b1;
        jump_pc = 32'h2000;
        #1;
        chk("drain_entry_req", ic.ic_req, 1'b1);
        cyc();
        jump = 1'b0;
        #1;
        chk("drain_old_addr", ic.ic_addr, 32'h1004);
        chk("drain_new_pc", itlb_vaddr, 32'h2000);
        chk("drain_req", ic.ic_req, 1'b1);
        cyc();
        ic.ic_hit  = 1'b1;
        ic.ic_data = 32'hDEAD;
        #1;
        cyc();
        ic.ic_data = 32'h77;
        push_instr(32'h77, 32'h2004);
        #1;
        chk("redirect_addr", ic.ic_addr, 32'h2000);
        chk("redirect_req", ic.ic_req, 1'b1);
        chk("drain_nop", dec_nop, 1'b1);
        cyc();
        ic.ic_hit = 1'b0;

        // iTLB miss at 0x3000.
        jump    = 1'b1;
        jump_pc = 32'h3000;
        #1;
        cyc();
        jump       = 1'b0;
        supervisor = 1'b0;
        itlb_miss  = 1'b1;
        exc_q.push_back(32'h3000);
        #1;
        chk("tlbmiss_no_req", ic.ic_req, 1'b0);
        cyc();
        itlb_miss  = 1'b0;
        supervisor = 1'b1;
        #1;
        chk("exc_req0", ic.ic_req, 1'b0);
        chk("exc_pc_frozen", itlb_vaddr, 32'h3000);
        chk("exc_raise_on", dec_exc_raise, 1'b1);
        cyc();
        jump    = 1'b1;
        jump_pc = 32'h2000;
        #1;
        chk("exc_pulse_end", dec_exc_raise, 1'b0);
        chk("exc_req1", ic.ic_req, 1'b0);
        chk("exc_nop", dec_nop, 1'b1);
        cyc();
        jump       = 1'b0;
        supervisor = 1'b0;
        tlb_off    = 32'h4000_0000;
        ic.ic_hit  = 1'b1;
        ic.ic_data = 32'h88;
        push_instr(32'h88, 32'h2004);
        #1;
        chk("translated_addr", ic.ic_addr, 32'h4000_2000);
        chk("exc_resume_pc", itlb_vaddr, 32'h2000);
        cyc();
        supervisor = 1'b1;
        tlb_off    = 32'h0;
        ic.ic_hit  = 1'b0;

        // Stall with jump and a fill landing during the stall.
        #1;
        cyc();
        stall      = 1'b1;
        jump       = 1'b1;
        jump_pc    = 32'h5000;
        ic.ic_hit  = 1'b1;
        ic.ic_data = 32'h99;
        #1;
        chk("stall_wait_req", ic.ic_req, 1'b1);
        cyc();
        ic.ic_hit = 1'b0;
        #1;
        chk("stall_pc_hold", itlb_vaddr, 32'h2004);
        chk("stall_nop_hold", dec_nop, 1'b1);
        cyc();
        stall = 1'b0;
        jump  = 1'b0;
        push_instr(32'h99, 32'h2008);
        #1;
        cyc();
        stall = 1'b1;
        #1;
        chk("jump_ignored", itlb_vaddr, 32'h2008);
        chk("run_stall_no_req", ic.ic_req, 1'b0);
        cyc();
        chk("stall_hold_instr", dec_instr, 32'h99);
        chk("stall_hold_next_pc", dec_next_pc, 32'h2008);
        chk("stall_hold_pc", itlb_vaddr, 32'h2008);
        stall      = 1'b0;
        ic.ic_hit  = 1'b1;
        ic.ic_data = 32'hAB;
        push_instr(32'hAB, 32'h200C);
        #1;
        cyc();
        ic.ic_hit = 1'b0;

        // PC wrap at the top of the address space.
        jump    = 1'b1;
        jump_pc = 32'hFFFF_FFFC;
        #1;
        cyc();
        jump       = 1'b0;
        ic.ic_hit  = 1'b1;
        ic.ic_data = 32'hCC;
        push_instr(32'hCC, 32'h0000_0000);
        #1;
        chk("wrap_fetch_addr", ic.ic_addr, 32'hFFFF_FFFC);
        cyc();
        ic.ic_hit = 1'b0;
        #1;
        chk("wrap_addr", ic.ic_addr, 32'h0000_0000);
        chk("wrap_pc", itlb_vaddr, 32'h0000_0000);
        cyc();

        // Reset in the middle of a miss; late hit during reset is ignored.
        reset      = 1'b1;
        ic.ic_hit  = 1'b1;
        ic.ic_data = 32'hEE;
        #1;
        chk("reset_midmiss_req", ic.ic_req, 1'b0);
        cyc();
        reset     = 1'b0;
        ic.ic_hit = 1'b0;
        #1;
        chk("midmiss_pc", itlb_vaddr, 32'h0000_1000);
        chk("midmiss_addr", ic.ic_addr, 32'h0000_1000);
        chk("midmiss_req", ic.ic_req, 1'b1);
        chk("midmiss_nop", dec_nop, 1'b1);
        ic.ic_hit  = 1'b1;
        ic.ic_data = 32'h11;
        push_instr(32'h11, 32'h1004);
        cyc();
        ic.ic_hit = 1'b0;
        repeat (3) cyc();

        chk("instr_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("exc_queue_empty", 32'(exc_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
